// File: rtl/keypad_pkg.sv
// Shared keypad types: row width, row index width and
// the press/release state encoding used by the row conditioner.
package keypad_pkg;

    localparam int ROW_W     = 4;
    localparam int ROW_IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        DOWN = 1'b1
    } kp_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One keypad row line: synchronizer chain, agreement counter
// and debounced output flop.
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic q,
    output logic q_next
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Any cycle where sync agrees with q restarts the count.
    always_comb begin
        q_next   = q;
        cnt_next = '0;
        if (sync != q) begin
            if (cnt == CNT_MAX) begin
                q_next = sync;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            q   <= 1'b0;
        end else begin
            cnt <= cnt_next;
            q   <= q_next;
        end
    end

endmodule

// File: rtl/keypad_row_conditioner.sv
// Debounced keypad row vector with press/release strobes,
// multi-key flag and lowest-set-bit row index.
module keypad_row_conditioner
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ROW_W-1:0]     row_raw,
    output logic [ROW_W-1:0]     row,
    output logic                 press,
    output logic                 released,
    output logic                 multi,
    output logic [ROW_IDX_W-1:0] row_idx
);

    logic [ROW_W-1:0] row_next;
    kp_state_t        state;

    for (genvar i = 0; i < ROW_W; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock (clock),
            .reset (reset),
            .raw   (row_raw[i]),
            .q     (row[i]),
            .q_next(row_next[i])
        );
    end

    // Strobes look at next-row so they line up with the row change.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            press    <= 1'b0;
            released <= 1'b0;
            case (state)
                IDLE: begin
                    if (row_next != '0) begin
                        state <= DOWN;
                        press <= 1'b1;
                    end
                end
                DOWN: begin
                    if (row_next == '0) begin
                        state    <= IDLE;
                        released <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign multi = (row & (row - ROW_W'(1))) != '0;

    always_comb begin
        row_idx = '0;
        unique case (1'b1)
            row[0]:                       row_idx = 2'd0;
            row[1] && !row[0]:            row_idx = 2'd1;
            row[2] && row[1:0] == 2'b00:  row_idx = 2'd2;
            row[3] && row[2:0] == 3'b000: row_idx = 2'd3;
            default:                      row_idx = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_keypad_row_conditioner.sv
// Scoreboard bench: stimulus posts expected strobes/snapshots,
// a negedge monitor retires them against the DUT.
module tb_keypad_row_conditioner;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_SNAP  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] row;
        logic       multi;
        logic [1:0] idx;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_raw = 4'b1111;
    logic [3:0] row;
    logic       press;
    logic       released;
    logic       multi;
    logic [1:0] row_idx;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t sb[$];

    keypad_row_conditioner dut (
        .clock   (clock),
        .reset   (reset),
        .row_raw (row_raw),
        .row     (row),
        .press   (press),
        .released(released),
        .multi   (multi),
        .row_idx (row_idx)
    );

    always #1 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic push(int kind, int dc, logic [3:0] r,
                        logic m, logic [1:0] ix);
        ev_t e;
        e.kind  = kind;
        e.cyc   = cyc + dc;
        e.row   = r;
        e.multi = m;
        e.idx   = ix;
        sb.push_back(e);
    endtask

    task automatic wait_n(int n);
        repeat (n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        bit hit;
        hit = 1'b0;
        if (press && released) chk("strobe_overlap", 1, 0);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk("press", {31'd0, press}, (sb[i].kind == K_PRESS) ? 1 : 0);
                chk("release", {31'd0, released}, (sb[i].kind == K_REL) ? 1 : 0);
                chk("row", {28'd0, row}, {28'd0, sb[i].row});
                chk("multi", {31'd0, multi}, {31'd0, sb[i].multi});
                chk("row_idx", {30'd0, row_idx}, {30'd0, sb[i].idx});
                if (sb[i].kind != K_SNAP) hit = 1'b1;
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                chk("missed_event", sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
        if ((press || released) && !hit)
            chk("unexpected_strobe", {30'd0, press, released}, 0);
    end

    initial begin
        // Reset held 3 edges with all rows high.
        push(K_SNAP, 1, 4'b0000, 1'b0, 2'd0);
        push(K_SNAP, 2, 4'b0000, 1'b0, 2'd0);
        push(K_SNAP, 3, 4'b0000, 1'b0, 2'd0);
        wait_n(3);
        reset = 1'b0;
        push(K_SNAP, 5, 4'b0000, 1'b0, 2'd0);
        push(K_PRESS, 6, 4'b1111, 1'b1, 2'd0);
        wait_n(10);
        row_raw = 4'b0000;
        push(K_REL, 6, 4'b0000, 1'b0, 2'd0);
        wait_n(10);

        // Clean press, long hold, release.
        row_raw = 4'b0001;
        push(K_SNAP, 5, 4'b0000, 1'b0, 2'd0);
        push(K_PRESS, 6, 4'b0001, 1'b0, 2'd0);
        push(K_SNAP, 25, 4'b0001, 1'b0, 2'd0);
        wait_n(26);
        row_raw = 4'b0000;
        push(K_REL, 6, 4'b0000, 1'b0, 2'd0);
        wait_n(10);

        // Glitch of 3 cycles rejected, 4 cycles accepted.
        row_raw = 4'b0010;
        wait_n(3);
        row_raw = 4'b0000;
        push(K_SNAP, 8, 4'b0000, 1'b0, 2'd0);
        wait_n(10);
        row_raw = 4'b0010;
        push(K_PRESS, 6, 4'b0010, 1'b0, 2'd1);
        wait_n(4);
        row_raw = 4'b0000;
        push(K_REL, 6, 4'b0000, 1'b0, 2'd0);
        wait_n(10);

        // Bounce every 2 cycles, then settle high.
        for (int i = 0; i < 6; i++) begin
            row_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            wait_n(2);
        end
        row_raw = 4'b0100;
        push(K_SNAP, 5, 4'b0000, 1'b0, 2'd0);
        push(K_PRESS, 6, 4'b0100, 1'b0, 2'd2);
        wait_n(10);
        row_raw = 4'b0000;
        push(K_REL, 6, 4'b0000, 1'b0, 2'd0);
        wait_n(10);

        // Two keys, then drop the lower one.
        row_raw = 4'b1010;
        push(K_PRESS, 6, 4'b1010, 1'b1, 2'd1);
        wait_n(10);
        row_raw = 4'b1000;
        push(K_SNAP, 5, 4'b1010, 1'b1, 2'd1);
        push(K_SNAP, 6, 4'b1000, 1'b0, 2'd3);
        wait_n(10);
        row_raw = 4'b0000;
        push(K_REL, 6, 4'b0000, 1'b0, 2'd0);
        wait_n(10);

        // Reset two cycles into a debounce count.
        row_raw = 4'b0001;
        wait_n(4);
        reset = 1'b1;
        push(K_SNAP, 1, 4'b0000, 1'b0, 2'd0);
        push(K_SNAP, 2, 4'b0000, 1'b0, 2'd0);
        wait_n(2);
        reset = 1'b0;
        push(K_PRESS, 6, 4'b0001, 1'b0, 2'd0);
        wait_n(10);

        // Reset while DOWN: no release, fresh press after.
        reset = 1'b1;
        push(K_SNAP, 1, 4'b0000, 1'b0, 2'd0);
        wait_n(1);
        reset = 1'b0;
        push(K_SNAP, 5, 4'b0000, 1'b0, 2'd0);
        push(K_PRESS, 6, 4'b0001, 1'b0, 2'd0);
        wait_n(10);
        row_raw = 4'b0000;
        push(K_REL, 6, 4'b0000, 1'b0, 2'd0);
        wait_n(10);

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
